uart_alu: RTL and testbench
===========================

Name: uart_alu

Overview:
- FPGA top-level block for an iCE40 board: UART (8N1) receiver, packet parser/ALU, UART transmitter and an activity LED.
- A host sends framed packets; the block either echoes the payload or returns the 32-bit sum of the payload operands.
- Sits directly on the board pins; the only clock is the board oscillator.

Parameters:
- ClkFreqHz, 12000000, input clock frequency in Hz.
- BaudRate, 115200, UART bit rate. CyclesPerBit = ClkFreqHz/BaudRate (integer division, 104 at defaults).
- EchoFifoDepth, 16, echo byte buffer depth in bytes (power of 2).

Ports:
- clk, input, 1, sole clock.
- rst, input, 1, synchronous active-high reset; one clock and one reset, reset sampled on the rising edge of clk.
- rx_i, input, 1, UART serial in; idle high; asynchronous to clk.
- tx_o, output, 1, UART serial out; idle high.
- led_o, output, 1, high while a packet is in progress.

Behaviour:
- Reset: tx_o=1, led_o=0; parser IDLE; FIFO empty; accumulator 0; RX and TX idle. Reset mid-packet or mid-byte aborts everything. tx_o returns to 1 the cycle after reset is sampled.
- RX path:
  - rx_i passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter; the start bit is re-checked at CyclesPerBit/2 and, if high, the frame is aborted.
  - 8 data bits are then sampled LSB-first, each CyclesPerBit apart, followed by the stop bit.
  - Stop bit=0 means framing error: the byte is discarded and RX waits for the line to go high.
  - A valid byte produces a 1-cycle rx_valid to the parser.
- TX path:
  - Sends start(0), 8 data bits LSB-first, stop(1), each held exactly CyclesPerBit cycles.
  - Accepts the next byte only when idle; back-to-back bytes need no extra idle bits.
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB, then (length-4) data bytes. Length is the total packet length including the header.
- Parser states: IDLE -> HDR (bytes 1..3) -> DATA -> RESP -> IDLE; DRAIN is used for unknown opcodes.
  - IDLE: any byte is taken as the opcode, sets led_o=1 and goes to HDR.
  - After byte3: length<=4 -> send the response immediately (RESP), or go straight to IDLE when there is nothing to send. Unknown opcode -> DRAIN.
  - DRAIN consumes the remaining (length-4) bytes silently, then IDLE.
- Opcode 0xEC (echo):
  - Each data byte is pushed into the echo FIFO on receipt; TX pops whenever idle.
  - FIFO full: the byte is dropped.
  - The packet ends once all data bytes are received and the FIFO is drained with TX idle.
- Opcode 0xAD (add32):
  - Data bytes form 32-bit little-endian operands.
  - The accumulator is cleared at the opcode; each complete operand is added modulo 2^32.
  - Trailing 1-3 bytes (length-4 not a multiple of 4) are ignored.
  - After the last byte, the 4-byte sum is transmitted LSB first.
  - Zero operands return 00 00 00 00.
- While in RESP or draining the echo FIFO, newly received bytes are dropped; a new packet is accepted only in IDLE.
- led_o goes 1 on the cycle the opcode byte is accepted. It returns to 0 the cycle the parser re-enters IDLE, which is after the final stop bit completes when there is a response.
- Length is 16-bit unsigned; lengths up to 65535 are supported and no timeout applies.

Test Plan:
- Reset, then hold rx_i=1 for 20 bit times -> tx_o stays 1 and led_o stays 0 throughout.
- Send EC 00 06 00 41 42 -> tx_o emits 0x41 then 0x42 with correct 8N1 timing (CyclesPerBit ±1 cycle per bit); led_o rises at byte0 and falls after the last stop bit.
- Send AD 00 0C 00 01 00 00 00 FF FF FF FF -> response 00 00 00 00 (wrap-around); second packet AD 00 0C 00 05 00 00 00 07 00 00 00 -> 0C 00 00 00.
- Send AD 00 07 00 11 22 33 -> partial operand ignored, response 00 00 00 00; then opcode 0x55 with length 6 and 2 data bytes -> no tx activity; a following EC packet echoes correctly.
- Framing error: send a byte with stop bit 0 in IDLE -> byte ignored, led_o stays 0; a false start (low pulse shorter than CyclesPerBit/2) -> no byte.
- Assert rst mid-way through an echo packet -> tx_o=1 and led_o=0 next cycle; a fresh AD 00 08 00 02 00 00 00 then returns 02 00 00 00.

Source files
------------

// File: rtl/uart_alu.sv
// uart_alu: iCE40 board top. An 8N1 UART receiver feeds a packet parser
// that either echoes the payload (opcode 0xEC) or returns the 32-bit sum of
// the little-endian payload operands (opcode 0xAD). Other opcodes are drained
// silently. Packet: opcode, reserved, length LSB, length MSB, then
// (length-4) data bytes; length counts the 4-byte header.
//
// Ports:
//   clk   - board oscillator, sole clock
//   rst   - synchronous active-high reset
//   rx_i  - UART serial in, idle high, asynchronous to clk
//   tx_o  - UART serial out, idle high
//   led_o - high while a packet is in progress
module uart_alu #(
    parameter int ClkFreqHz     = 12000000,
    parameter int BaudRate      = 115200,
    parameter int EchoFifoDepth = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic tx_o,
    output logic led_o
);

    localparam int CyclesPerBit = ClkFreqHz / BaudRate;
    localparam int CntW         = $clog2(CyclesPerBit);
    localparam int PtrW         = $clog2(EchoFifoDepth);
    localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CyclesPerBit / 2 - 1);
    localparam logic [7:0] OpEcho = 8'hEC;
    localparam logic [7:0] OpAdd  = 8'hAD;

    // ---------------------------------------------------------------- RX
    logic rx_meta_q, rx_sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid;
    logic [7:0]      rx_byte;

    assign rx_byte = rx_shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CntW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                // The line can only be low here after having been high, so a
                // low level marks the falling edge of a start bit.
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BitLast) begin
                    rx_valid   = rx_sync_q;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- TX
    logic            tx_q, tx_busy_q;
    logic [8:0]      tx_shift_q;
    logic [3:0]      tx_bit_q;
    logic [CntW-1:0] tx_cnt_q;
    logic            tx_ready, tx_start;
    logic [7:0]      tx_data;

    // The last cycle of the stop bit counts as ready, so a queued byte starts
    // exactly CyclesPerBit after the stop bit began.
    assign tx_ready = !tx_busy_q || (tx_cnt_q == BitLast && tx_bit_q == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else if (tx_start) begin
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_shift_q <= {1'b1, tx_data};
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BitLast) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CntW'(1);
            end
        end
    end

    assign tx_o = tx_q;

    // ---------------------------------------------------------- echo FIFO
    logic [7:0]    fifo_mem [EchoFifoDepth];
    logic [PtrW:0] wr_ptr_q, rd_ptr_q;
    logic          fifo_push, fifo_pop, fifo_empty, fifo_full;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and a reset-free array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------- parser
    typedef enum logic [2:0] {P_IDLE, P_HDR, P_DATA, P_RESP, P_DRAIN} p_state_e;

    p_state_e    p_state_q, p_state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] remain_q, remain_d;
    logic [31:0] acc_q, acc_d;
    logic [23:0] operand_q, operand_d;   // first three bytes of the current operand
    logic [1:0]  op_byte_q, op_byte_d;
    logic [2:0]  resp_cnt_q, resp_cnt_d;
    logic [15:0] len_full, data_len;

    assign len_full = {rx_byte, len_lo_q};
    assign data_len = (len_full > 16'd4) ? len_full - 16'd4 : 16'd0;
    assign led_o    = (p_state_q != P_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q  <= P_IDLE;
            opcode_q   <= '0;
            hdr_cnt_q  <= '0;
            len_lo_q   <= '0;
            remain_q   <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            op_byte_q  <= '0;
            resp_cnt_q <= '0;
        end else begin
            p_state_q  <= p_state_d;
            opcode_q   <= opcode_d;
            hdr_cnt_q  <= hdr_cnt_d;
            len_lo_q   <= len_lo_d;
            remain_q   <= remain_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            op_byte_q  <= op_byte_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    always_comb begin
        p_state_d  = p_state_q;
        opcode_d   = opcode_q;
        hdr_cnt_d  = hdr_cnt_q;
        len_lo_d   = len_lo_q;
        remain_d   = remain_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        op_byte_d  = op_byte_q;
        resp_cnt_d = resp_cnt_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        tx_start   = 1'b0;
        tx_data    = fifo_mem[rd_ptr_q[PtrW-1:0]];
        unique case (p_state_q)
            P_IDLE: begin
                if (rx_valid) begin
                    opcode_d   = rx_byte;
                    hdr_cnt_d  = '0;
                    acc_d      = '0;
                    operand_d  = '0;
                    op_byte_d  = '0;
                    resp_cnt_d = '0;
                    p_state_d  = P_HDR;
                end
            end
            P_HDR: begin
                if (rx_valid) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd1) len_lo_d = rx_byte;
                    if (hdr_cnt_q == 2'd2) begin
                        remain_d = data_len;
                        if (opcode_q == OpAdd)
                            p_state_d = (data_len == 16'd0) ? P_RESP : P_DATA;
                        else if (opcode_q == OpEcho)
                            p_state_d = (data_len == 16'd0) ? P_IDLE : P_DATA;
                        else
                            p_state_d = (data_len == 16'd0) ? P_IDLE : P_DRAIN;
                    end
                end
            end
            P_DATA: begin
                if (opcode_q == OpEcho) begin
                    // Bytes beyond the declared length, or arriving while the
                    // FIFO is full, are dropped.
                    if (rx_valid && remain_q != 16'd0) begin
                        remain_d  = remain_q - 16'd1;
                        fifo_push = !fifo_full;
                    end
                    if (tx_ready && !fifo_empty) begin
                        tx_start = 1'b1;
                        fifo_pop = 1'b1;
                    end
                    if (remain_q == 16'd0 && fifo_empty && !tx_busy_q) p_state_d = P_IDLE;
                end else if (rx_valid) begin
                    // Little-endian assembly: bytes shift in from the top, so
                    // the fourth byte completes {b3, b2, b1, b0}. A trailing
                    // partial operand never reaches the accumulator.
                    remain_d  = remain_q - 16'd1;
                    op_byte_d = op_byte_q + 2'd1;
                    operand_d = {rx_byte, operand_q[23:8]};
                    if (op_byte_q == 2'd3) acc_d = acc_q + {rx_byte, operand_q};
                    if (remain_q == 16'd1) p_state_d = P_RESP;
                end
            end
            P_RESP: begin
                // The sum leaves LSB first by shifting the accumulator down.
                if (resp_cnt_q != 3'd4) begin
                    if (tx_ready) begin
                        tx_start   = 1'b1;
                        tx_data    = acc_q[7:0];
                        acc_d      = acc_q >> 8;
                        resp_cnt_d = resp_cnt_q + 3'd1;
                    end
                end else if (!tx_busy_q) begin
                    p_state_d = P_IDLE;
                end
            end
            P_DRAIN: begin
                if (rx_valid) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) p_state_d = P_IDLE;
                end
            end
            default: p_state_d = P_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_alu.sv
// tb_uart_alu: drives framed packets into uart_alu over rx_i, decodes the
// serial stream on tx_o, and compares it with the response computed from the
// packet contents by a byte-level reference model.
module tb_uart_alu;

    localparam int ClkHz = 1600000;
    localparam int Baud  = 100000;
    localparam int Cpb   = ClkHz / Baud;   // 16 cycles per bit

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_i = 1'b1;
    logic tx_o, led_o;

    always #5 clk = ~clk;

    uart_alu #(
        .ClkFreqHz(ClkHz),
        .BaudRate(Baud),
        .EchoFifoDepth(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_i(rx_i),
        .tx_o(tx_o),
        .led_o(led_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    logic [7:0] pkt_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       mon_abort;
    logic       last_stop_led = 1'b0;

    // ------------------------------------------------------ serial monitor
    task automatic mon_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
        end
    endtask

    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx_o === 1'b0) begin
                mon_abort = 1'b0;
                b = '0;
                mon_wait(Cpb / 2 - 1);
                if (!mon_abort) check("tx_start_bit", 32'(tx_o), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(Cpb);
                    b[i] = tx_o;
                end
                mon_wait(Cpb);
                if (!mon_abort) begin
                    check("tx_stop_bit", 32'(tx_o), 32'd1);
                    last_stop_led = led_o;
                    got_q.push_back(b);
                end
            end
        end
    end

    // ------------------------------------------------------ host driver
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (Cpb) @(negedge clk);
        end
        rx_i = stop;
        repeat (Cpb) @(negedge clk);
        rx_i = 1'b1;
    endtask

    // ------------------------------------------------------ reference model
    task automatic build_expected();
        int          ndata;
        logic [15:0] len;
        logic [31:0] sum;
        exp_q.delete();
        len   = {pkt_q[3], pkt_q[2]};
        ndata = (len > 16'd4) ? int'(len) - 4 : 0;
        if (pkt_q[0] == 8'hEC) begin
            for (int i = 0; i < ndata; i++) exp_q.push_back(pkt_q[4 + i]);
        end else if (pkt_q[0] == 8'hAD) begin
            sum = 32'd0;
            for (int k = 0; k + 4 <= ndata; k += 4)
                sum = sum + {pkt_q[7 + k], pkt_q[6 + k], pkt_q[5 + k], pkt_q[4 + k]};
            for (int i = 0; i < 4; i++) exp_q.push_back(sum[8*i +: 8]);
        end
    endtask

    task automatic send_packet(input int gaps);
        foreach (pkt_q[i]) begin
            send_byte(pkt_q[i], 1'b1);
            if (i == 0) check("led_on_opcode", 32'(led_o), 32'd1);
            if (gaps != 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic finish_packet();
        int waited = 0;
        while (led_o !== 1'b0 && waited < Cpb * 60) begin
            @(negedge clk);
            waited++;
        end
        check("led_release", 32'(led_o), 32'd0);
        repeat (Cpb) @(negedge clk);
        check("resp_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("resp_byte", 32'(got_q[i]), 32'(exp_q[i]));
        if (exp_q.size() != 0) check("led_high_at_last_stop", 32'(last_stop_led), 32'd1);
        got_q.delete();
    endtask

    task automatic run_packet(input int gaps);
        build_expected();
        send_packet(gaps);
        finish_packet();
    endtask

    // ------------------------------------------------------ stimulus
    initial begin
        int bad_tx, bad_led, waited, ndata;
        logic [7:0] op;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_tx", 32'(tx_o), 32'd1);
        check("reset_led", 32'(led_o), 32'd0);
        rst = 1'b0;

        // Idle line for 20 bit times.
        bad_tx  = 0;
        bad_led = 0;
        repeat (20 * Cpb) begin
            @(negedge clk);
            if (tx_o !== 1'b1) bad_tx++;
            if (led_o !== 1'b0) bad_led++;
        end
        check("idle_tx_low_cycles", 32'(bad_tx), 32'd0);
        check("idle_led_high_cycles", 32'(bad_led), 32'd0);

        pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
        run_packet(0);
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_packet(0);
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                  8'h07, 8'h00, 8'h00, 8'h00};
        run_packet(0);
        pkt_q = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
        run_packet(0);
        pkt_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        run_packet(0);
        pkt_q = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h10, 8'h00, 8'hFF};
        run_packet(0);

        // Framing error in IDLE: stop bit low.
        send_byte(8'h5A, 1'b0);
        repeat (Cpb * 3) @(negedge clk);
        check("framing_led", 32'(led_o), 32'd0);
        check("framing_tx_bytes", 32'(got_q.size()), 32'd0);

        // False start: low pulse shorter than half a bit.
        rx_i = 1'b0;
        repeat (Cpb / 2 - 3) @(negedge clk);
        rx_i = 1'b1;
        repeat (Cpb * 12) @(negedge clk);
        check("false_start_led", 32'(led_o), 32'd0);
        check("false_start_tx_bytes", 32'(got_q.size()), 32'd0);

        pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
        run_packet(0);

        // Reset while the first echoed byte is on the wire.
        pkt_q = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h41};
        foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
        waited = 0;
        while (tx_o !== 1'b0 && waited < Cpb * 20) begin
            @(negedge clk);
            waited++;
        end
        check("echo_started_before_reset", 32'(tx_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_tx", 32'(tx_o), 32'd1);
        check("reset_mid_led", 32'(led_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (Cpb * 12) @(negedge clk);
        got_q.delete();
        pkt_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        run_packet(0);

        // Randomized packets.
        for (int p = 0; p < 10; p++) begin
            case ($urandom_range(0, 2))
                0:       op = 8'hEC;
                1:       op = 8'hAD;
                default: begin
                    do op = 8'($urandom); while (op == 8'hEC || op == 8'hAD);
                end
            endcase
            ndata = $urandom_range(0, 9);
            pkt_q.delete();
            pkt_q.push_back(op);
            pkt_q.push_back(8'($urandom));
            if (ndata == 0) begin
                pkt_q.push_back(8'($urandom_range(0, 4)));
            end else begin
                pkt_q.push_back(8'(ndata + 4));
            end
            pkt_q.push_back(8'h00);
            for (int i = 0; i < ndata; i++) pkt_q.push_back(8'($urandom));
            run_packet(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
